// File: rtl/ram_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
package ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_t;
endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output skid buffer: captured RAM words in, valid/ready stream out.
module ram_fifo_obuf
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [1:0]        o_occ
);
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_valid;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_tail_valid;
  logic              w_pop;

  assign w_pop = r_head_valid && i_pop_ready;

  // The head register is the output, so out_data/out_valid come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_data  <= '0;
      r_head_valid <= 1'b0;
      r_tail_data  <= '0;
      r_tail_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head_data  <= r_tail_data;
        r_head_valid <= 1'b1;
      end else if (i_push) begin
        r_head_data  <= i_push_data;
        r_head_valid <= 1'b1;
      end else begin
        r_head_valid <= 1'b0;
      end
      if (r_tail_valid && i_push) begin
        r_tail_data  <= i_push_data;
        r_tail_valid <= 1'b1;
      end else begin
        r_tail_valid <= 1'b0;
      end
    end else if (i_push) begin
      if (!r_head_valid) begin
        r_head_data  <= i_push_data;
        r_head_valid <= 1'b1;
      end else begin
        r_tail_data  <= i_push_data;
        r_tail_valid <= 1'b1;
      end
    end
  end

  assign o_data  = r_head_data;
  assign o_valid = r_head_valid;
  assign o_occ   = {1'b0, r_head_valid} + {1'b0, r_tail_valid};
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using an external 64x8 single-port synchronous RAM as storage,
// with round-robin write/read arbitration and a 2-entry output buffer.
module ram_fifo_ctrl
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_r,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_out
);
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_inflight;
  rr_t               r_rr;
  rr_t               w_rr_next;
  logic [1:0]        w_occ;
  logic [2:0]        w_pending;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_wr_req;
  logic              w_wr_grant;
  logic              w_rd_grant;

  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_wr_elig = r_ram_cnt < CNT_DEPTH;
  assign w_rd_elig = (r_ram_cnt != '0) && (w_pending < 3'd2);
  assign w_wr_req  = in_valid && w_wr_elig;

  // Grants are masked during reset so the RAM never sees an enable while rst is high.
  always_comb begin
    w_wr_grant  = 1'b0;
    w_rd_grant  = 1'b0;
    in_ready    = 1'b0;
    w_rr_next   = r_rr;
    ram_en      = 1'b0;
    ram_r       = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (!rst) begin
      in_ready   = w_wr_elig && !(w_rd_elig && r_rr == RR_READ);
      w_wr_grant = w_wr_req && !(w_rd_elig && r_rr == RR_READ);
      w_rd_grant = w_rd_elig && !(w_wr_req && r_rr == RR_WRITE);
      if (w_wr_req && w_rd_elig) begin
        w_rr_next = (r_rr == RR_WRITE) ? RR_READ : RR_WRITE;
      end
      if (w_wr_grant) begin
        ram_en      = 1'b1;
        ram_address = r_wr_ptr;
        ram_data    = in_data;
      end else if (w_rd_grant) begin
        ram_en      = 1'b1;
        ram_r       = 1'b1;
        ram_address = r_rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_rr       <= RR_WRITE;
    end else begin
      r_rr       <= w_rr_next;
      r_inflight <= w_rd_grant;
      if (w_wr_grant) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end else if (w_rd_grant) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end
    end
  end

  // RAM read data is valid only the cycle after the grant; capture it then.
  ram_fifo_obuf u_obuf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (ram_out),
    .i_pop_ready (out_ready),
    .o_data      (out_data),
    .o_valid     (out_valid),
    .o_occ       (w_occ)
  );

  assign count = r_ram_cnt + (ADDR_W + 1)'(r_inflight) + (ADDR_W + 1)'(w_occ);
  assign full  = r_ram_cnt == CNT_DEPTH;
  assign empty = count == '0;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed testbench for ram_fifo_ctrl with a behavioural 64x8 synchronous RAM.
module tb_ram_fifo_ctrl;
  import ram_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] ram_data;
  logic              ram_r;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_en;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Single-port synchronous RAM: registered read, output floats while disabled.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_r) ram_q <= mem[ram_address];
      else       mem[ram_address] <= ram_data;
    end else begin
      ram_q <= 'z;
    end
  end

  ram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .ram_data(ram_data), .ram_r(ram_r), .ram_address(ram_address), .ram_en(ram_en),
    .ram_out(ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int acc = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    for (int c = 0; c < 20 && acc < 3; c++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    n_checks++;
    if (count !== 7'd3) begin n_fail++; $display("FAIL reset_preload count got %0d exp 3", count); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got %b exp 0", ram_en); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++;
    if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++;
    if (out_valid !== 1'b0 || full !== 1'b0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_outs got ov=%b full=%b od=%h exp 0 0 00", out_valid, full, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || ram_en !== 1'b1 || ram_r !== 1'b0 || ram_address !== 6'd0 || ram_data !== 8'h11) begin
      n_fail++; $display("FAIL single_write got rdy=%b en=%b r=%b a=%h d=%h exp 1 1 0 00 11",
                         in_ready, ram_en, ram_r, ram_address, ram_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b1 || ram_r !== 1'b1 || ram_address !== 6'd0) begin
      n_fail++; $display("FAIL single_read_c1 got en=%b r=%b a=%h exp 1 1 00", ram_en, ram_r, ram_address);
    end
    tick(); #1;
    n_checks++;
    if (out_valid !== 1'b0 || ram_en !== 1'b0 || ram_address !== 6'd0 || ram_data !== 8'h00) begin
      n_fail++; $display("FAIL single_c2 got ov=%b en=%b a=%h d=%h exp 0 0 00 00", out_valid, ram_en, ram_address, ram_data);
    end
    tick(); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_fail++; $display("FAIL single_c3 got ov=%b od=%h exp 1 11", out_valid, out_data);
    end
    tick(); #1;
    n_checks++;
    if (count !== 7'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_after got cnt=%0d empty=%b ov=%b exp 0 1 0", count, empty, out_valid);
    end
    out_ready = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_fill();
    int acc = 0;
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_valid = 1'b1; in_data = 8'(acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    #1;
    n_checks++;
    if (acc != 66) begin n_fail++; $display("FAIL fill_accepted got %0d exp 66", acc); end
    n_checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 7'd66) begin
      n_fail++; $display("FAIL fill_flags got full=%b rdy=%b cnt=%0d exp 1 0 66", full, in_ready, count);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL fill_head got ov=%b od=%h exp 1 00", out_valid, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 300 && idx < 66; c++) begin
      #1;
      if (out_valid) begin
        n_checks++;
        if (out_data !== 8'(idx)) begin n_fail++; $display("FAIL fill_drain[%0d] got %h exp %h", idx, out_data, 8'(idx)); end
        idx++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (idx != 66 || empty !== 1'b1) begin
      n_fail++; $display("FAIL fill_drained got n=%0d empty=%b exp 66 1", idx, empty);
    end
    $display("test_fill done");
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr = 6'd3;
    logic [ADDR_W-1:0] prev_addr = 6'd0;
    int sent = 0, rcv = 0, wraps = 0, bad = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && rcv < 150; c++) begin
      in_valid = (sent < 150); in_data = 8'(sent);
      #1;
      if (ram_en && !ram_r) begin
        if (ram_address !== exp_addr) bad++;
        if (prev_addr == 6'd63 && ram_address == 6'd0) wraps++;
        prev_addr = ram_address;
        exp_addr  = exp_addr + 1'b1;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        n_checks++;
        if (out_data !== 8'(rcv)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", rcv, out_data, 8'(rcv)); end
        rcv++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wrap_waddr got %0d bad addresses exp 0", bad); end
    n_checks++;
    if (wraps != 2) begin n_fail++; $display("FAIL wrap_count got %0d exp 2", wraps); end
    n_checks++;
    if (sent != 150 || rcv != 150 || empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_totals got sent=%0d rcv=%0d empty=%b exp 150 150 1", sent, rcv, empty);
    end
    $display("test_wrap done");
  endtask

  task automatic test_contention();
    logic [7:0] expq[$];
    logic [7:0] nxt = 8'hC0;
    logic prev_r = 1'b0;
    logic is_r, is_w;
    int alt_bad = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && expq.size() < 4; c++) begin
      in_valid = 1'b1; in_data = nxt;
      #1;
      if (in_ready) begin expq.push_back(nxt); nxt++; end
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = nxt;
      #1;
      is_r = ram_en && ram_r;
      is_w = ram_en && !ram_r;
      n_checks++;
      if (count !== 7'(expq.size())) begin n_fail++; $display("FAIL cont_count[%0d] got %0d exp %0d", c, count, expq.size()); end
      if (c >= 4) begin
        if (ram_en !== 1'b1 || is_r == prev_r || in_ready !== is_w) alt_bad++;
      end
      prev_r = is_r;
      if (out_valid) begin
        n_checks++;
        if (out_data !== expq[0]) begin n_fail++; $display("FAIL cont_data got %h exp %h", out_data, expq[0]); end
        void'(expq.pop_front());
      end
      if (in_ready) begin expq.push_back(nxt); nxt++; end
      tick();
    end
    n_checks++;
    if (alt_bad != 0) begin n_fail++; $display("FAIL cont_alternation got %0d bad cycles exp 0", alt_bad); end
    in_valid = 1'b0;
    for (int c = 0; c < 50 && expq.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        n_checks++;
        if (out_data !== expq[0]) begin n_fail++; $display("FAIL cont_drain got %h exp %h", out_data, expq[0]); end
        void'(expq.pop_front());
      end
      tick();
    end
    #1;
    n_checks++;
    if (expq.size() != 0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL cont_end got left=%0d empty=%b exp 0 1", expq.size(), empty);
    end
    $display("test_contention done");
  endtask

  task automatic test_reset_read();
    int got = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b1 || ram_r !== 1'b1) begin n_fail++; $display("FAIL rr_grant got en=%b r=%b exp 1 1", ram_en, ram_r); end
    tick();
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick(); #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 7'd0) begin
      n_fail++; $display("FAIL rr_after_rst got ov=%b cnt=%0d exp 0 0", out_valid, count);
    end
    tick(); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_discard got ov=%b exp 0", out_valid); end
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    n_checks++;
    if (ram_en !== 1'b1 || ram_r !== 1'b0 || ram_address !== 6'd0 || ram_data !== 8'hA5) begin
      n_fail++; $display("FAIL rr_write got en=%b r=%b a=%h d=%h exp 1 0 00 a5", ram_en, ram_r, ram_address, ram_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b1 || ram_r !== 1'b1 || ram_address !== 6'd0) begin
      n_fail++; $display("FAIL rr_read got en=%b r=%b a=%h exp 1 1 00", ram_en, ram_r, ram_address);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got == 0; c++) begin
      #1;
      if (out_valid) begin
        got = 1;
        n_checks++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL rr_data got %h exp a5", out_data); end
      end
      tick();
    end
    n_checks++;
    if (got != 1) begin n_fail++; $display("FAIL rr_timeout got no output exp a5"); end
    $display("test_reset_read done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_contention();
    test_reset_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
